// File: rtl/tx_status_elevador.sv
// tx_status_elevador
// UART transmitter for the SmartCargo status report. On request it sends one
// header byte {01, floor, count}, one byte {10, 00, tipo, destino} per object
// held in the contents RAM, and a 0x0A terminator, each LSB-first.
// Default frame is 8N1. Defining TX_STATUS_PARIDADE_EN adds an even-parity
// bit before the stop bit (8E1, 11-bit frames).
// The two bookkeeping states between bytes (PROXIMO, CARREGA) are taken out
// of the preceding stop bit, so the byte-to-byte period is exactly one frame.
// The last stop bit of a packet is full length.
module tx_status_elevador #(
   parameter int TICKS_POR_BIT = 434,
   parameter int W_TICK        = 9
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       partida,
   input  logic [1:0] andar_atual,
   input  logic [3:0] num_objetos,
   output logic [3:0] mem_addr,
   input  logic [1:0] mem_tipo,
   input  logic [1:0] mem_destino,
   output logic       TX,
   output logic       ocupado,
   output logic       pronto,
   output logic [3:0] db_estado
);

   typedef enum logic [3:0] {
      INICIAL   = 4'd0,
      CARREGA   = 4'd1,
      TRANSMITE = 4'd2,
      PROXIMO   = 4'd3,
      FIM       = 4'd4
   } estado_t;

   // Bit slot numbering inside a frame: 0 = start, 1..8 = data, then
   // optional parity, then stop.
`ifdef TX_STATUS_PARIDADE_EN
   localparam logic [3:0] BIT_STOP = 4'd10;
`else
   localparam logic [3:0] BIT_STOP = 4'd9;
`endif
   localparam logic [3:0] BIT_ULTIMO_DADO = 4'd8;

   // Last tick index of a normal bit and of a shortened (inter-byte) stop bit.
   localparam logic [W_TICK-1:0] TICK_LAST  = W_TICK'(TICKS_POR_BIT - 1);
   localparam logic [W_TICK-1:0] SHORT_LAST =
      (TICKS_POR_BIT >= 3) ? W_TICK'(TICKS_POR_BIT - 3) : '0;
   // With two ticks per bit the shortened stop bit has no ticks of its own:
   // the line simply stays high through PROXIMO and CARREGA.
   localparam bit SHORT_STOP_ZERO = (TICKS_POR_BIT == 2);

   estado_t           estadoReg, estadoNext;
   logic [W_TICK-1:0] baudReg, baudNext;
   logic [3:0]        bitReg, bitNext;
   logic [7:0]        shiftReg, shiftNext;
   logic [4:0]        indexReg, indexNext;
   logic [1:0]        andarReg, andarNext;
   logic [3:0]        numReg, numNext;
   logic [3:0]        addrReg, addrNext;
   logic              txReg, txNext;
`ifdef TX_STATUS_PARIDADE_EN
   logic              parityReg, parityNext;
`endif

   logic [7:0]        byteCarga;
   logic [4:0]        numMaisUm;
   logic              ultimoByte;
   logic [W_TICK-1:0] stopLast;
   logic              fimBit;

   // Index is 5 bits wide so that N+1 = 16 is representable for N = 15.
   assign numMaisUm  = {1'b0, numReg} + 5'd1;
   assign ultimoByte = (indexReg == numMaisUm);
   assign stopLast   = ultimoByte ? TICK_LAST : SHORT_LAST;
   assign fimBit     = (bitReg == BIT_STOP) ? (baudReg == stopLast)
                                            : (baudReg == TICK_LAST);

   // Byte to transmit for the current packet index.
   always_comb begin
      byteCarga = 8'h0A;
      if (indexReg == 5'd0) begin
         byteCarga = {2'b01, andarReg, numReg};
      end else if (indexReg <= {1'b0, numReg}) begin
         byteCarga = {2'b10, 2'b00, mem_tipo, mem_destino};
      end
   end

   // State register and datapath registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estadoReg <= INICIAL;
         baudReg   <= '0;
         bitReg    <= '0;
         shiftReg  <= '0;
         indexReg  <= '0;
         andarReg  <= '0;
         numReg    <= '0;
         addrReg   <= '0;
         txReg     <= 1'b1;
`ifdef TX_STATUS_PARIDADE_EN
         parityReg <= 1'b0;
`endif
      end else begin
         estadoReg <= estadoNext;
         baudReg   <= baudNext;
         bitReg    <= bitNext;
         shiftReg  <= shiftNext;
         indexReg  <= indexNext;
         andarReg  <= andarNext;
         numReg    <= numNext;
         addrReg   <= addrNext;
         txReg     <= txNext;
`ifdef TX_STATUS_PARIDADE_EN
         parityReg <= parityNext;
`endif
      end
   end

   // Next-state and next-datapath logic.
   always_comb begin
      estadoNext = estadoReg;
      baudNext   = baudReg;
      bitNext    = bitReg;
      shiftNext  = shiftReg;
      indexNext  = indexReg;
      andarNext  = andarReg;
      numNext    = numReg;
      addrNext   = addrReg;
      txNext     = txReg;
`ifdef TX_STATUS_PARIDADE_EN
      parityNext = parityReg;
`endif

      case (estadoReg)
         INICIAL: begin
            txNext = 1'b1;
            if (partida) begin
               andarNext  = andar_atual;
               numNext    = num_objetos;
               indexNext  = 5'd0;
               addrNext   = 4'd0;
               estadoNext = CARREGA;
            end
         end

         CARREGA: begin
            // RAM data is valid this cycle because mem_addr was set on entry.
            shiftNext  = byteCarga;
`ifdef TX_STATUS_PARIDADE_EN
            parityNext = ^byteCarga;
`endif
            txNext     = 1'b0;
            baudNext   = '0;
            bitNext    = 4'd0;
            estadoNext = TRANSMITE;
         end

         TRANSMITE: begin
            if (!fimBit) begin
               baudNext = baudReg + W_TICK'(1);
            end else if (bitReg == BIT_STOP) begin
               baudNext   = '0;
               txNext     = 1'b1;
               estadoNext = PROXIMO;
            end else begin
               baudNext = '0;
               bitNext  = bitReg + 4'd1;
               if (bitReg < BIT_ULTIMO_DADO) begin
                  txNext    = shiftReg[0];
                  shiftNext = {1'b0, shiftReg[7:1]};
               end
`ifdef TX_STATUS_PARIDADE_EN
               else if (bitReg == BIT_ULTIMO_DADO) begin
                  txNext = parityReg;
               end
`endif
               else begin
                  txNext = 1'b1;
               end
               if (SHORT_STOP_ZERO && !ultimoByte && (bitNext == BIT_STOP)) begin
                  estadoNext = PROXIMO;
               end
            end
         end

         PROXIMO: begin
            txNext = 1'b1;
            if (ultimoByte) begin
               estadoNext = FIM;
            end else begin
               indexNext = indexReg + 5'd1;
               // Next index is an object byte: point the RAM at object index-1.
               if (indexReg < {1'b0, numReg}) begin
                  addrNext = indexReg[3:0];
               end
               estadoNext = CARREGA;
            end
         end

         FIM: begin
            txNext     = 1'b1;
            estadoNext = INICIAL;
         end

         default: begin
            txNext     = 1'b1;
            estadoNext = INICIAL;
         end
      endcase
   end

   assign TX        = txReg;
   assign mem_addr  = addrReg;
   assign db_estado = estadoReg;
   assign ocupado   = (estadoReg != INICIAL) && (estadoReg != FIM);
   assign pronto    = (estadoReg == FIM);

endmodule
